// File: rtl/mac_acc_if.sv
// mac_acc_if: operand stream in, result stream out, for the mac_acc block.
// master = operand source / result consumer side, slave = the MAC itself.
interface mac_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18,
    parameter int CNT_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out;
    logic [CNT_W-1:0]         beats;
    logic                     ovf;

    modport master (
        output in_valid, a, b, last, out_ready,
        input  in_ready, out_valid, out, beats, ovf
    );

    modport slave (
        input  in_valid, a, b, last, out_ready,
        output in_ready, out_valid, out, beats, ovf
    );
endinterface

// File: rtl/mac_acc.sv
// mac_acc: pipelined signed multiply-accumulate over vectors delimited by
// last, one result (dot product, beat count, sticky overflow) per vector.
// Optional feature: define MAC_SATURATE_EN to clamp the accumulator on
// overflow instead of two's-complement wrap.
module mac_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18,
    parameter int CNT_W  = 8
) (
    input logic     clk,
    input logic     rst,
    mac_acc_if.slave bus
);

    typedef enum logic [1:0] {S_ACC, S_DRAIN, S_HOLD} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_rst_done;
    logic                       w_in_ready;
    logic                       w_accept;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [2*DATA_W-1:0] r_prod;
    logic                       r_p_valid;
    logic                       r_p_last;

    logic                       r_first;
    logic [ACC_W-1:0]           r_acc;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_ovf_acc;
    logic [ACC_W:0]             w_base;
    logic [ACC_W:0]             w_prod_ext;
    logic [ACC_W:0]             w_sum;
    logic                       w_ovf_bit;
    logic [ACC_W-1:0]           w_acc_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic                       w_ovf_nxt;

    logic [ACC_W-1:0]           r_out;
    logic [CNT_W-1:0]           r_beats;
    logic                       r_ovf;
    logic                       r_out_valid;

    assign w_accept      = bus.in_valid && w_in_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.beats     = r_beats;
    assign bus.ovf       = r_ovf;

    // State register; r_rst_done keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_ACC;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
        end
    end

    // Next-state and in_ready decode (registered state only, no path from out_ready).
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_ACC: begin
                w_in_ready = r_rst_done;
                if (bus.in_valid && r_rst_done && bus.last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_HOLD;
            S_HOLD:  if (bus.out_ready) w_state_nxt = S_ACC;
            default: w_state_nxt = S_ACC;
        endcase
    end

    assign w_prod = $signed({{DATA_W{bus.a[DATA_W-1]}}, bus.a})
                  * $signed({{DATA_W{bus.b[DATA_W-1]}}, bus.b});

    // Stage 1: register the product of each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod    <= '0;
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= w_accept;
            r_p_last  <= w_accept && bus.last;
            if (w_accept) r_prod <= w_prod;
        end
    end

    // Stage 2 arithmetic: one guard bit above the accumulator exposes overflow.
    always_comb begin
        w_base     = r_first ? '0 : {r_acc[ACC_W-1], r_acc};
        w_prod_ext = {{(ACC_W+1-2*DATA_W){r_prod[2*DATA_W-1]}}, r_prod};
        w_sum      = w_base + w_prod_ext;
        w_ovf_bit  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef MAC_SATURATE_EN
        if (!w_ovf_bit)
            w_acc_nxt = w_sum[ACC_W-1:0];
        else if (w_sum[ACC_W])
            w_acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
        else
            w_acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
`else
        w_acc_nxt = w_sum[ACC_W-1:0];
`endif
        w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        w_ovf_nxt = r_ovf_acc | w_ovf_bit;
    end

    // Stage 2 state and result registers; the final beat loads the result and rearms for the next vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first     <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out       <= '0;
            r_beats     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;
            if (r_p_valid) begin
                r_acc <= w_acc_nxt;
                if (r_p_last) begin
                    r_out       <= w_acc_nxt;
                    r_beats     <= w_cnt_nxt;
                    r_ovf       <= w_ovf_nxt;
                    r_out_valid <= 1'b1;
                    r_first     <= 1'b1;
                    r_cnt       <= '0;
                    r_ovf_acc   <= 1'b0;
                end else begin
                    r_cnt       <= w_cnt_nxt;
                    r_ovf_acc   <= w_ovf_nxt;
                    r_first     <= 1'b0;
                end
            end
        end
    end

endmodule
